// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Imported by the fetch FSM and its helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;

  localparam int PC_INC = 4;

endpackage

// File: rtl/pc_adder.sv
// Combinational modular adder for PC arithmetic.
// Used for both the sequential PC and the redirect target.
module pc_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and single-outstanding instruction fetch unit.
// Buffers one word for decode and applies branch redirects.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc,
  input  logic                   PCsrc,
  input  logic [PC_WIDTH-1:0]    PC_Target,
  input  logic [PC_WIDTH-1:0]    br_base,
  output logic [PC_WIDTH-1:0]    PC,
  output logic                   misaligned
);

  localparam logic [PC_WIDTH-1:0] INC =
    PC_WIDTH'(PC_INC);

  fetch_state_t state_q, state_d;

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic                   valid_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]    ifpc_q;
  logic                   mis_q;
  logic                   mis_set;
  logic                   capture;
  logic [PC_WIDTH-1:0]    pc_seq;
  logic [PC_WIDTH-1:0]    tgt;

  pc_adder #(.W(PC_WIDTH)) u_seq_add (
    .a   (pc_q),
    .b   (INC),
    .sum (pc_seq)
  );

  pc_adder #(.W(PC_WIDTH)) u_tgt_add (
    .a   (br_base),
    .b   (PC_Target),
    .sum (tgt)
  );

  // Redirect beats every other event; an ack on the
  // same cycle only retires the now-stale request.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_set = 1'b0;
    capture = 1'b0;
    if (PCsrc) begin
      pc_d    = {tgt[PC_WIDTH-1:2], 2'b00};
      mis_set = |tgt[1:0];
      unique case (state_q)
        S_BOOT:  state_d = S_REQ;
        S_REQ:   state_d = imem_ack ? S_REQ : S_DRAIN;
        S_HOLD:  state_d = S_REQ;
        S_DRAIN: state_d = imem_ack ? S_REQ : S_DRAIN;
        default: state_d = S_BOOT;
      endcase
    end else begin
      unique case (state_q)
        S_BOOT: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            capture = 1'b1;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (if_ready) begin
            pc_d    = pc_seq;
            state_d = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_ack) state_d = S_REQ;
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  // The address only moves when a fresh request starts,
  // so it stays frozen across a drain.
  always_comb begin
    addr_d = addr_q;
    if (state_d == S_REQ) addr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      valid_q <= (state_d == S_HOLD);
      if (mis_set) mis_q <= 1'b1;
      if (capture) begin
        instr_q <= imem_rdata;
        ifpc_q  <= pc_q;
      end
    end
  end

  assign imem_req   = (state_q == S_REQ) ||
                      (state_q == S_DRAIN);
  assign imem_addr  = addr_q;
  assign if_valid   = valid_q;
  assign if_instr   = instr_q;
  assign if_pc      = ifpc_q;
  assign PC         = pc_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer.
// Per-cycle stimulus with hand-computed expected outputs.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [15:0] if_pc;
  logic        PCsrc;
  logic [15:0] PC_Target;
  logic [15:0] br_base;
  logic [15:0] PC;
  logic        misaligned;

  int n_vec;
  int n_bad;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        src;
    logic [15:0] tgt;
    logic [15:0] base;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_ifpc;
    logic [31:0] e_instr;
    logic [15:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];

  fetch_sequencer #(
    .PC_WIDTH    (16),
    .INSTR_WIDTH (32),
    .RESET_PC    (16'h0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .PCsrc      (PCsrc),
    .PC_Target  (PC_Target),
    .br_base    (br_base),
    .PC         (PC),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic add(
    input logic ack, input logic [31:0] rdata,
    input logic ready, input logic src,
    input logic [15:0] tgt, input logic [15:0] base,
    input logic e_req, input logic [15:0] e_addr,
    input logic e_valid, input logic [15:0] e_ifpc,
    input logic [31:0] e_instr, input logic [15:0] e_pc,
    input logic e_mis);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready;
    v.src = src; v.tgt = tgt; v.base = base;
    v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_ifpc = e_ifpc;
    v.e_instr = e_instr; v.e_pc = e_pc;
    v.e_mis = e_mis;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input vec_t v);
    logic [82:0] act, exp;
    act = {imem_req, imem_addr, if_valid, if_pc,
           if_instr, PC, misaligned};
    exp = {v.e_req, v.e_addr, v.e_valid, v.e_ifpc,
           v.e_instr, v.e_pc, v.e_mis};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got req=%b addr=%h vld=%b ifpc=%h instr=%h pc=%h mis=%b, want req=%b addr=%h vld=%b ifpc=%h instr=%h pc=%h mis=%b",
        name, imem_req, imem_addr, if_valid, if_pc,
        if_instr, PC, misaligned, v.e_req, v.e_addr,
        v.e_valid, v.e_ifpc, v.e_instr, v.e_pc,
        v.e_mis);
    end
  endtask

  // Drive inputs early in the cycle, check, then advance.
  task automatic run_vec(input string name, input vec_t v);
    imem_ack   = v.ack;
    imem_rdata = v.rdata;
    if_ready   = v.ready;
    PCsrc      = v.src;
    PC_Target  = v.tgt;
    br_base    = v.base;
    #1;
    check(name, v);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I0   = 32'h1000_0000;
  localparam logic [31:0] I4   = 32'h1000_0004;
  localparam logic [31:0] I8   = 32'h1000_0008;
  localparam logic [31:0] I30  = 32'h1000_0030;
  localparam logic [31:0] I28  = 32'h1000_0028;
  localparam logic [31:0] IFC  = 32'h1000_FFFC;
  localparam logic [31:0] I104 = 32'h1000_0104;
  localparam logic [31:0] I300 = 32'h1000_0300;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  initial begin
    vec_t r;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    if_ready = 1'b0; PCsrc = 1'b0;
    PC_Target = '0; br_base = '0;

    // ack ready src tgt base | req addr vld ifpc instr pc mis
    add(0, 0,    0, 0, 0, 0,  0, 16'h0000, 0, 16'h0000, 0,    16'h0000, 0);
    add(1, I0,   0, 0, 0, 0,  1, 16'h0000, 0, 16'h0000, 0,    16'h0000, 0);
    add(0, 0,    1, 0, 0, 0,  0, 16'h0000, 1, 16'h0000, I0,   16'h0000, 0);
    add(1, I4,   0, 0, 0, 0,  1, 16'h0004, 0, 16'h0000, I0,   16'h0004, 0);
    add(0, 0,    1, 0, 0, 0,  0, 16'h0004, 1, 16'h0004, I4,   16'h0004, 0);
    add(0, 0,    0, 0, 0, 0,  1, 16'h0008, 0, 16'h0004, I4,   16'h0008, 0);
    add(0, 0,    0, 0, 0, 0,  1, 16'h0008, 0, 16'h0004, I4,   16'h0008, 0);
    add(0, 0,    0, 0, 0, 0,  1, 16'h0008, 0, 16'h0004, I4,   16'h0008, 0);
    add(1, I8,   0, 0, 0, 0,  1, 16'h0008, 0, 16'h0004, I4,   16'h0008, 0);
    add(0, 0,    0, 0, 0, 0,  0, 16'h0008, 1, 16'h0008, I8,   16'h0008, 0);
    add(0, 0,    0, 0, 0, 0,  0, 16'h0008, 1, 16'h0008, I8,   16'h0008, 0);
    add(0, 0,    0, 0, 0, 0,  0, 16'h0008, 1, 16'h0008, I8,   16'h0008, 0);
    add(0, 0,    0, 0, 0, 0,  0, 16'h0008, 1, 16'h0008, I8,   16'h0008, 0);
    add(0, 0,    1, 0, 0, 0,  0, 16'h0008, 1, 16'h0008, I8,   16'h0008, 0);
    add(0, 0,    0, 1, 16'h0020, 16'h0010,
                              1, 16'h000C, 0, 16'h0008, I8,   16'h000C, 0);
    add(0, 0,    0, 0, 0, 0,  1, 16'h000C, 0, 16'h0008, I8,   16'h0030, 0);
    add(1, DEAD, 0, 0, 0, 0,  1, 16'h000C, 0, 16'h0008, I8,   16'h0030, 0);
    add(1, I30,  0, 0, 0, 0,  1, 16'h0030, 0, 16'h0008, I8,   16'h0030, 0);
    add(0, 0,    0, 1, 16'h000A, 16'h0020,
                              0, 16'h0030, 1, 16'h0030, I30,  16'h0030, 0);
    add(1, I28,  0, 0, 0, 0,  1, 16'h0028, 0, 16'h0030, I30,  16'h0028, 1);
    add(0, 0,    1, 1, 16'h000C, 16'hFFF0,
                              0, 16'h0028, 1, 16'h0028, I28,  16'h0028, 1);
    add(1, IFC,  0, 0, 0, 0,  1, 16'hFFFC, 0, 16'h0028, I28,  16'hFFFC, 1);
    add(0, 0,    1, 0, 0, 0,  0, 16'hFFFC, 1, 16'hFFFC, IFC,  16'hFFFC, 1);
    add(1, DEAD, 0, 1, 16'h0004, 16'h0100,
                              1, 16'h0000, 0, 16'hFFFC, IFC,  16'h0000, 1);
    add(1, I104, 0, 0, 0, 0,  1, 16'h0104, 0, 16'hFFFC, IFC,  16'h0104, 1);
    add(0, 0,    0, 0, 0, 0,  0, 16'h0104, 1, 16'h0104, I104, 16'h0104, 1);

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      run_vec($sformatf("vec%0d", i), tbl[i]);

    // Asynchronous reset while a word is buffered.
    #1 rst_n = 1'b0;
    #1;
    r = tbl[0];
    check("async_reset", r);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Restart from RESET_PC, then redirect into and
    // during a drain.
    tbl.delete();
    add(0, 0,    0, 0, 0, 0,  0, 16'h0000, 0, 16'h0000, 0,    16'h0000, 0);
    add(1, I0,   0, 0, 0, 0,  1, 16'h0000, 0, 16'h0000, 0,    16'h0000, 0);
    add(0, 0,    1, 0, 0, 0,  0, 16'h0000, 1, 16'h0000, I0,   16'h0000, 0);
    add(0, 0,    0, 1, 16'h0000, 16'h0200,
                              1, 16'h0004, 0, 16'h0000, I0,   16'h0004, 0);
    add(0, 0,    0, 1, 16'h0000, 16'h0300,
                              1, 16'h0004, 0, 16'h0000, I0,   16'h0200, 0);
    add(1, DEAD, 0, 0, 0, 0,  1, 16'h0004, 0, 16'h0000, I0,   16'h0300, 0);
    add(1, I300, 0, 0, 0, 0,  1, 16'h0300, 0, 16'h0000, I0,   16'h0300, 0);
    add(0, 0,    0, 0, 0, 0,  0, 16'h0300, 1, 16'h0300, I300, 16'h0300, 0);

    for (int i = 0; i < tbl.size(); i++)
      run_vec($sformatf("post_rst%0d", i), tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
